// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic, bus geometry and FSM state type for the RS syndrome
// sequencer; no ports (package only).
package gf_pkg;

    localparam int SYMB_WIDTH        = 8;
    localparam int BUS_WIDTH_IN_SYMB = 4;
    localparam logic [SYMB_WIDTH:0]   PRIM_POLY = 9'h11D;
    localparam logic [SYMB_WIDTH-1:0] ALPHA     = 8'h02;

    typedef enum logic [2:0] {
        CAPTURE,
        REPLAY,
        WAIT,
        OUT,
        DROP
    } rs_seq_state_t;

    // Shift-and-add multiply, reducing by the primitive polynomial each step
    function automatic logic [SYMB_WIDTH-1:0] gf_mult(
        input logic [SYMB_WIDTH-1:0] a,
        input logic [SYMB_WIDTH-1:0] b
    );
        logic [SYMB_WIDTH-1:0] p;
        logic [SYMB_WIDTH-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) p = p ^ x;
            if (x[SYMB_WIDTH-1])
                x = {x[SYMB_WIDTH-2:0], 1'b0} ^ PRIM_POLY[SYMB_WIDTH-1:0];
            else
                x = {x[SYMB_WIDTH-2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] gf_pow(
        input logic [SYMB_WIDTH-1:0] a,
        input int                    n
    );
        logic [SYMB_WIDTH-1:0] r;
        r = 1;
        for (int i = 0; i < n; i++) r = gf_mult(r, a);
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_seq_if.sv
// Bundle of the codeword input stream, engine replay port and syndrome output.
// slave: the sequencer's view; master: the surrounding environment's view.
interface rs_syndrome_seq_if import gf_pkg::*; #(
    parameter int ROOTS_NUM = 16
);
    localparam int DW = BUS_WIDTH_IN_SYMB * SYMB_WIDTH;

    logic                            s_tvalid;
    logic                            s_tready;
    logic [DW-1:0]                   s_tdata;
    logic [BUS_WIDTH_IN_SYMB-1:0]    s_tkeep;
    logic                            s_tlast;
    logic                            e_tvalid;
    logic [DW-1:0]                   e_tdata;
    logic [BUS_WIDTH_IN_SYMB-1:0]    e_tkeep;
    logic                            e_tlast;
    logic [SYMB_WIDTH-1:0]           e_root;
    logic [SYMB_WIDTH-1:0]           e_syndrome;
    logic                            m_tvalid;
    logic                            m_tready;
    logic [ROOTS_NUM*SYMB_WIDTH-1:0] m_tdata;
    logic                            m_nonzero;
    logic                            s_overflow;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, e_syndrome, m_tready,
        output s_tready, e_tvalid, e_tdata, e_tkeep, e_tlast, e_root,
        output m_tvalid, m_tdata, m_nonzero, s_overflow
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, e_syndrome, m_tready,
        input  s_tready, e_tvalid, e_tdata, e_tkeep, e_tlast, e_root,
        input  m_tvalid, m_tdata, m_nonzero, s_overflow
    );

endinterface

// File: rtl/rs_cw_buffer.sv
// Codeword beat store: one write port, one combinational read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module rs_cw_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rs_syndrome_seq.sv
// Captures one codeword, replays it once per root into an external Horner
// engine, collects the syndromes. Ports: aclk, areset, bus (slave view).
module rs_syndrome_seq import gf_pkg::*; #(
    parameter int MAX_BEATS  = 64,
    parameter int ROOTS_NUM  = 16,
    parameter int FCR        = 0,
    parameter int ENGINE_LAT = 1
) (
    input  logic              aclk,
    input  logic              areset,
    rs_syndrome_seq_if.slave  bus
);

    localparam int SW = SYMB_WIDTH;
    localparam int KW = BUS_WIDTH_IN_SYMB;
    localparam int DW = KW * SW;
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam int AW = $clog2(MAX_BEATS);
    localparam int IW = $clog2(ROOTS_NUM + 1);
    localparam int LW = $clog2(ENGINE_LAT + 1);
    localparam logic [SW-1:0] ROOT0 = gf_pow(ALPHA, FCR);

    rs_seq_state_t          state_q, state_d;
    logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]          beats_q, beats_d;
    logic [KW-1:0]          last_keep_q, last_keep_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [LW-1:0]          lat_cnt_q, lat_cnt_d;
    logic [SW-1:0]          root_q, root_d;
    logic [ROOTS_NUM*SW-1:0] syndr_q, syndr_d;
    logic                   s_tready_q, s_tready_d;
    logic                   e_tvalid_q, e_tvalid_d;
    logic                   e_tlast_q, e_tlast_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   s_overflow_q, s_overflow_d;

    logic                   beat_acc;
    logic                   buf_we;
    logic [DW-1:0]          buf_rdata;

    assign beat_acc = bus.s_tvalid & s_tready_q;
    assign buf_we   = beat_acc & (state_q == CAPTURE);

    rs_cw_buffer #(
        .DEPTH (MAX_BEATS),
        .WIDTH (DW),
        .AW    (AW)
    ) u_buf (
        .clk   (aclk),
        .we    (buf_we),
        .waddr (wr_cnt_q[AW-1:0]),
        .wdata (bus.s_tdata),
        .raddr (rd_cnt_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        beats_d      = beats_q;
        last_keep_d  = last_keep_q;
        idx_d        = idx_q;
        lat_cnt_d    = lat_cnt_q;
        root_d       = root_q;
        syndr_d      = syndr_q;
        s_tready_d   = s_tready_q;
        e_tvalid_d   = e_tvalid_q;
        e_tlast_d    = e_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        s_overflow_d = 1'b0;
        unique case (state_q)
            CAPTURE: begin
                s_tready_d = 1'b1;
                if (beat_acc) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (bus.s_tlast) begin
                        last_keep_d = bus.s_tkeep;
                        beats_d     = wr_cnt_q + 1'b1;
                        idx_d       = '0;
                        rd_cnt_d    = '0;
                        root_d      = ROOT0;
                        s_tready_d  = 1'b0;
                        e_tvalid_d  = 1'b1;
                        e_tlast_d   = (wr_cnt_q == '0);
                        state_d     = REPLAY;
                    end else if (wr_cnt_q == CW'(MAX_BEATS - 1)) begin
                        s_overflow_d = 1'b1;
                        state_d      = DROP;
                    end
                end
            end
            REPLAY: begin
                if (e_tlast_q) begin
                    e_tvalid_d = 1'b0;
                    e_tlast_d  = 1'b0;
                    lat_cnt_d  = '0;
                    state_d    = WAIT;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    // e_tlast is registered, so look one beat ahead
                    e_tlast_d = (rd_cnt_q + CW'(2) == beats_q);
                end
            end
            WAIT: begin
                if (lat_cnt_q == LW'(ENGINE_LAT - 1)) begin
                    syndr_d[idx_q*SW +: SW] = bus.e_syndrome;
                    root_d = gf_mult(root_q, ALPHA);
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IW'(ROOTS_NUM - 1)) begin
                        m_tvalid_d = 1'b1;
                        state_d    = OUT;
                    end else begin
                        rd_cnt_d   = '0;
                        e_tvalid_d = 1'b1;
                        e_tlast_d  = (beats_q == CW'(1));
                        state_d    = REPLAY;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.m_tready) begin
                    m_tvalid_d = 1'b0;
                    wr_cnt_d   = '0;
                    s_tready_d = 1'b1;
                    state_d    = CAPTURE;
                end
            end
            DROP: begin
                s_tready_d = 1'b1;
                if (beat_acc && bus.s_tlast) begin
                    wr_cnt_d = '0;
                    state_d  = CAPTURE;
                end
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= CAPTURE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            beats_q      <= '0;
            last_keep_q  <= '0;
            idx_q        <= '0;
            lat_cnt_q    <= '0;
            root_q       <= ROOT0;
            syndr_q      <= '0;
            s_tready_q   <= 1'b0;
            e_tvalid_q   <= 1'b0;
            e_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            s_overflow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            beats_q      <= beats_d;
            last_keep_q  <= last_keep_d;
            idx_q        <= idx_d;
            lat_cnt_q    <= lat_cnt_d;
            root_q       <= root_d;
            syndr_q      <= syndr_d;
            s_tready_q   <= s_tready_d;
            e_tvalid_q   <= e_tvalid_d;
            e_tlast_q    <= e_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            s_overflow_q <= s_overflow_d;
        end
    end

    // Buffer contents are not reset, so gate the replay data with valid
    assign bus.s_tready   = s_tready_q;
    assign bus.e_tvalid   = e_tvalid_q;
    assign bus.e_tdata    = e_tvalid_q ? buf_rdata : '0;
    assign bus.e_tkeep    = e_tvalid_q ? (e_tlast_q ? last_keep_q : '1) : '0;
    assign bus.e_tlast    = e_tlast_q;
    assign bus.e_root     = root_q;
    assign bus.m_tvalid   = m_tvalid_q;
    assign bus.m_tdata    = syndr_q;
    assign bus.m_nonzero  = |syndr_q;
    assign bus.s_overflow = s_overflow_q;

endmodule

// File: doc/rs_syndrome_seq.md
Name: rs_syndrome_seq

Overview:
- Time-shared syndrome controller for the RS decoder front end.
- Captures one AXI-Stream codeword into a local buffer, then replays it ROOTS_NUM times into a single Horner syndrome engine (rs_syndrome_horney), with root alpha^(FCR+i) for pass i.
- Collects the engine result after each pass and presents the full syndrome vector to the key-equation solver on an AXI-Stream-like output with backpressure.

Parameters:
- SYMB_WIDTH, gf_pkg value (8): symbol width in bits.
- BUS_WIDTH_IN_SYMB, gf_pkg value (4): symbols per beat.
- MAX_BEATS, 64: buffer depth in beats, equal to ceil(255/4).
- ROOTS_NUM, 16: number of syndromes (2T).
- FCR, 0: first consecutive root power.
- ENGINE_LAT, 1: cycles from the engine e_tlast beat to a valid e_syndrome.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input ready
- s_tdata  in  BUS_WIDTH_IN_SYMB*SYMB_WIDTH  codeword symbols; lane 0 is the highest-degree coefficient
- s_tkeep  in  BUS_WIDTH_IN_SYMB  lane valid; all ones except on the last beat
- s_tlast  in  1  last beat of codeword
- e_tvalid  out  1  engine beat valid
- e_tdata  out  BUS_WIDTH_IN_SYMB*SYMB_WIDTH  replayed data
- e_tkeep  out  BUS_WIDTH_IN_SYMB  replayed keep
- e_tlast  out  1  replayed last
- e_root  out  SYMB_WIDTH  evaluation root for the current pass
- e_syndrome  in  SYMB_WIDTH  engine result
- m_tvalid  out  1  syndrome vector valid
- m_tready  in  1  downstream ready
- m_tdata  out  ROOTS_NUM*SYMB_WIDTH  S_0..S_(ROOTS_NUM-1); S_i in slice i
- m_nonzero  out  1  OR-reduction of all syndromes (error present)
- s_overflow  out  1  one-cycle pulse when a frame is dropped

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values:
  - 0: s_tready, e_tvalid, e_tlast, e_tdata, e_tkeep, m_tvalid, m_tdata, m_nonzero, s_overflow.
  - e_root resets to alpha^FCR.
  - State machine resets to CAPTURE.
- States: CAPTURE, REPLAY, WAIT, OUT, DROP.
- CAPTURE:
  - s_tready=1.
  - Each s_tvalid&s_tready beat writes data to buffer[wr_cnt], then wr_cnt++.
  - The tlast beat also latches last_keep and beats=wr_cnt+1.
  - On the tlast beat: go to REPLAY with idx=0, rd_cnt=0, e_root=alpha^FCR.
  - If wr_cnt==MAX_BEATS-1 and the beat has no tlast: pulse s_overflow and go to DROP.
- DROP:
  - s_tready=1; beats are discarded.
  - On a tlast beat: go to CAPTURE with wr_cnt=0.
- REPLAY:
  - e_tvalid=1 every cycle; the engine has no backpressure.
  - e_tdata=buffer[rd_cnt]; e_tkeep is all ones, or last_keep on the final beat.
  - e_tlast=(rd_cnt==beats-1).
  - After the last beat: go to WAIT with lat_cnt=0.
  - e_root is stable for the whole pass.
- WAIT:
  - lat_cnt counts to ENGINE_LAT.
  - At the final count: syndr[idx] <= e_syndrome; e_root <= gf_mult(e_root, alpha); idx++.
  - If idx==ROOTS_NUM-1: go to OUT. Otherwise go to REPLAY with rd_cnt=0.
- OUT:
  - m_tvalid=1 with m_tdata/m_nonzero stable until m_tready.
  - On the handshake: go to CAPTURE, wr_cnt=0, m_tvalid deasserted next cycle.
  - s_tready=0 outside CAPTURE/DROP; there is no capture/replay overlap in this revision.
- Latency: for a B-beat frame, m_tvalid rises B + ROOTS_NUM*(B+ENGINE_LAT) cycles after the first accepted beat.
- Boundaries:
  - Single-beat frame (B=1) is legal.
  - tlast exactly on beat MAX_BEATS is accepted; no overflow.
  - Counters are sized clog2(MAX_BEATS+1) and clog2(ROOTS_NUM+1).
  - GF arithmetic uses gf_pkg multiply only; there is no integer overflow path.
  - m_tready held high when m_tvalid rises gives a one-cycle OUT state.
  - Reset asserted mid-REPLAY/WAIT/OUT aborts the frame: e_tvalid and m_tvalid drop immediately, and the partial syndromes are cleared.

Decomposition:
- gf_pkg holds: SYMB_WIDTH, BUS_WIDTH_IN_SYMB, primitive polynomial (0x11D), ALPHA constant, gf_mult function, and an rs_seq_state_t enum.
- The buffer is a single-port-read / single-port-write RAM, sub-module rs_cw_buffer (MAX_BEATS x BUS_WIDTH_IN_SYMB*SYMB_WIDTH + keep). Reads are combinational, or registered with a one-cycle read prefetch.
- The engine is instantiated outside this block, next to it.

Test Plan:
- All-zero 255-symbol codeword, 64 beats, last_keep=4'b0111 -> m_tdata all 0x00, m_nonzero=0, m_tvalid at cycle 64+16*65=1104.
- Zero codeword with lowest-degree symbol (last lane of last beat) = 0x01 -> every S_i=0x01, m_nonzero=1.
- Zero codeword with degree-1 symbol = 0x01, FCR=0 -> S_i=alpha^i: 01,02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26.
- m_tready held low 50 cycles in OUT -> m_tvalid and m_tdata stable, s_tready=0; handshake, then the next frame is captured correctly.
- 70 beats with no tlast, then tlast -> s_overflow pulses once at beat 64, no m_tvalid; the following valid frame yields correct syndromes.
- areset pulsed during REPLAY of pass 7 -> all outputs at reset values within the same cycle; a fresh frame then completes with correct S_0..S_15.
